mbinit_lane_reversal_fsm: RTL and testbench
===========================================

MBINIT_LANE_REVERSAL_FSM -- requirements
Module: mbinit_lane_reversal_fsm

Interface
REQ-001 SHALL: NUM_LANES, 16, data lanes checked (8..64).
REQ-002 SHALL: PASS_THRESH, NUM_LANES/2+1, minimum count of passing lanes for a PASS.
REQ-003 SHALL: MAX_REV_ATTEMPTS, 1, maximum reversal applications before train error (1..3).
REQ-004 SHALL: RESP_TIMEOUT, 8000, maximum CLK cycles in WAIT_RESP before timeout.
REQ-005 SHALL: Reset rst_n, asynchronous, active-low; clock CLK.
REQ-006 SHALL: CLK  in  1  block clock.
REQ-007 SHALL: rst_n  in  1  async active-low reset.
REQ-008 SHALL: i_start  in  1  level enable from the preceding MBINIT step; low aborts to IDLE.
REQ-009 SHALL: i_sb_busy / i_sb_busy_fall  in  1/1  sideband busy level / one-cycle falling-edge pulse.
REQ-010 SHALL: i_rx_msg, i_rx_msg_valid  in  4, 1  received sideband message code and qualifier.
REQ-011 SHALL: i_result  in  NUM_LANES  per-lane pass bitmap, valid with result_resp.
REQ-012 SHALL: i_pattern_done / i_reversal_done  in  1/1  LFSR pattern complete / reversal applied.
REQ-013 SHALL: o_tx_msg, o_tx_valid  out  4, 1  sideband request code and valid.
REQ-014 SHALL: o_pattern_en  out  2  LFSR mode; 2'b11 = per-lane ID pattern, else 0.
REQ-015 SHALL: o_apply_reversal, o_reversed  out  1, 1  reversal-apply strobe; sticky "lanes reversed" flag.
REQ-016 SHALL: o_done, o_train_error  out  1, 1  step complete (level); one-cycle error pulse.
REQ-017 SHALL: o_attempts  out  2  reversal attempts used.

Function
REQ-018 SHALL: message codes init_req 1, init_resp 2, clear_error_req 3, clear_error_resp 4, result_req 5, result_resp 6, done_req 7, done_resp 8.
REQ-019 SHALL: states IDLE, WAIT_BUSY, SEND, WAIT_RESP, PATTERN, EVAL, APPLY, DONE, ERROR.
REQ-020 SHALL: request order init -> clear_error -> (PATTERN) -> result -> EVAL -> done; after APPLY, resume at clear_error.
REQ-021 SHALL: IDLE -> WAIT_BUSY with request init_req when i_start=1.
REQ-022 SHALL: WAIT_BUSY -> SEND when i_sb_busy=0.
REQ-023 SHALL: SEND drives o_tx_valid=1 and the pending code until i_sb_busy_fall, then -> WAIT_RESP.
REQ-024 SHALL: WAIT_RESP accepts only the response matching the pending request; other valid codes are ignored.
REQ-025 SHALL: init_resp -> WAIT_BUSY(clear_error_req); clear_error_resp -> PATTERN; result_resp -> EVAL; done_resp -> DONE.
REQ-026 SHALL: PATTERN drives o_pattern_en=2'b11 until i_pattern_done, then -> WAIT_BUSY(result_req).
REQ-027 SHALL: popcount of i_result registered on result_resp acceptance; width $clog2(NUM_LANES+1).
REQ-028 SHALL: EVAL, 1 cycle: count>=PASS_THRESH -> WAIT_BUSY(done_req); else attempts<MAX_REV_ATTEMPTS -> APPLY; else -> ERROR.
REQ-029 SHALL: APPLY pulses o_apply_reversal on entry, toggles o_reversed, increments attempts, waits i_reversal_done -> WAIT_BUSY(clear_error_req).
REQ-030 SHALL: timeout counter clears on WAIT_RESP entry; reaching RESP_TIMEOUT -> ERROR.
REQ-031 SHALL: ERROR entry pulses o_train_error for exactly 1 cycle; ERROR holds until i_start=0.
REQ-032 SHALL: DONE holds o_done=1 until i_start=0.
REQ-033 SHALL: i_start=0 in any state -> IDLE next cycle; attempts, o_reversed, and the counters clear; o_tx_valid drops in the same cycle.
REQ-034 SHALL: all outputs registered; o_tx_valid rises 1 cycle after WAIT_BUSY sees busy=0.
REQ-035 SHALL: response and timeout in the same cycle -> response wins.

Reset
REQ-036 SHALL: reset sets state IDLE, all outputs 0, attempts 0, popcount 0, timeout counter 0.

Structure
REQ-037 SHALL: message codes, state enum, and LFSR mode codes live in shared package mbinit_pkg.
REQ-038 SHALL: popcount is sub-module lane_popcount #(NUM_LANES); the FSM stays in the top module.

Verification
REQ-039 SHALL: NUM_LANES=16, i_result=16'hFFFF on first result_resp -> codes 1,3,5,7 sent in order; o_done=1; o_reversed=0.
REQ-040 SHALL: first i_result=16'h00FF (8<9) -> o_apply_reversal pulse, clear_error_req resent; second i_result=16'hFFFF -> o_done=1, o_reversed=1, o_attempts=1.
REQ-041 SHALL: MAX_REV_ATTEMPTS=1, both results 16'h0001 -> exactly one o_train_error pulse; state ERROR; no done_req sent.
REQ-042 SHALL: RESP_TIMEOUT=100, no response after init_req -> o_train_error at cycle 100 after WAIT_RESP entry.
REQ-043 SHALL: i_start dropped during PATTERN -> next cycle IDLE, o_pattern_en=0; restart resends init_req.
REQ-044 SHALL: NUM_LANES=64, i_result with 33 ones -> pass; with 32 ones -> APPLY.

Source files
------------

// File: rtl/mbinit_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mbinit_pkg
//  Description : Shared codes for the MBINIT lane-reversal step: sideband
//                message codes, FSM state encoding and LFSR mode codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package mbinit_pkg;

   // Sideband message codes; every response is its request code plus one
   localparam logic [3:0] c_msg_none             = 4'd0;
   localparam logic [3:0] c_msg_init_req         = 4'd1;
   localparam logic [3:0] c_msg_init_resp        = 4'd2;
   localparam logic [3:0] c_msg_clear_error_req  = 4'd3;
   localparam logic [3:0] c_msg_clear_error_resp = 4'd4;
   localparam logic [3:0] c_msg_result_req       = 4'd5;
   localparam logic [3:0] c_msg_result_resp      = 4'd6;
   localparam logic [3:0] c_msg_done_req         = 4'd7;
   localparam logic [3:0] c_msg_done_resp        = 4'd8;

   // LFSR pattern generator modes
   localparam logic [1:0] c_pat_off     = 2'b00;
   localparam logic [1:0] c_pat_lane_id = 2'b11;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_WAIT_BUSY = 4'd1,
      ST_SEND      = 4'd2,
      ST_WAIT_RESP = 4'd3,
      ST_PATTERN   = 4'd4,
      ST_EVAL      = 4'd5,
      ST_APPLY     = 4'd6,
      ST_DONE      = 4'd7,
      ST_ERROR     = 4'd8
   } state_t;

   // Response code that completes a given request
   function automatic logic [3:0] resp_code(input logic [3:0] req);
      return req + 4'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lane_popcount.sv
`default_nettype none
// ============================================================================
//  Module      : lane_popcount
//  Description : Combinational count of set bits in the per-lane pass map.
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_popcount #(
   parameter int NUM_LANES = 16
) (
   input  logic [NUM_LANES-1:0]         i_lanes,
   output logic [$clog2(NUM_LANES+1)-1:0] o_count
);

   localparam int CW = $clog2(NUM_LANES + 1);

   // Sum of passing lanes
   always_comb begin
      o_count = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         o_count = o_count + CW'(i_lanes[k]);
      end
   end

endmodule
`default_nettype wire

// File: rtl/mbinit_lane_reversal_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : mbinit_lane_reversal_fsm
//  Description : MBINIT lane-reversal step. Runs the sideband handshake
//                init -> clear_error -> pattern -> result -> done, evaluates
//                the lane pass count and retries with lanes reversed when too
//                few lanes pass.
//  Revision    : 1.0 - initial release
// ============================================================================
module mbinit_lane_reversal_fsm
   import mbinit_pkg::*;
#(
   parameter int NUM_LANES        = 16,
   parameter int PASS_THRESH      = NUM_LANES / 2 + 1,
   parameter int MAX_REV_ATTEMPTS = 1,
   parameter int RESP_TIMEOUT     = 8000
) (
   input  logic                 CLK,
   input  logic                 rst_n,
   input  logic                 i_start,
   input  logic                 i_sb_busy,
   input  logic                 i_sb_busy_fall,
   input  logic [3:0]           i_rx_msg,
   input  logic                 i_rx_msg_valid,
   input  logic [NUM_LANES-1:0] i_result,
   input  logic                 i_pattern_done,
   input  logic                 i_reversal_done,
   output logic [3:0]           o_tx_msg,
   output logic                 o_tx_valid,
   output logic [1:0]           o_pattern_en,
   output logic                 o_apply_reversal,
   output logic                 o_reversed,
   output logic                 o_done,
   output logic                 o_train_error,
   output logic [1:0]           o_attempts
);

   localparam int CW = $clog2(NUM_LANES + 1);
   localparam int TW = $clog2(RESP_TIMEOUT + 1);

   localparam logic [CW-1:0] c_pass_thresh = CW'(PASS_THRESH);
   localparam logic [1:0]    c_max_rev     = 2'(MAX_REV_ATTEMPTS);
   localparam logic [TW-1:0] c_tmo_last    = TW'(RESP_TIMEOUT - 1);

   state_t        state_q,      state_d;
   logic [3:0]    pend_q,       pend_d;
   logic [CW-1:0] count_q,      count_d;
   logic [TW-1:0] tmo_q,        tmo_d;
   logic [1:0]    attempts_q,   attempts_d;
   logic          reversed_q,   reversed_d;
   logic          tx_valid_q,   tx_valid_d;
   logic [3:0]    tx_msg_q,     tx_msg_d;
   logic [1:0]    pattern_en_q, pattern_en_d;
   logic          apply_q,      apply_d;
   logic          done_q,       done_d;
   logic          train_err_q,  train_err_d;

   logic [CW-1:0] w_popcount;
   logic          w_resp_hit;

   lane_popcount #(
      .NUM_LANES (NUM_LANES)
   ) u_popcount (
      .i_lanes (i_result),
      .o_count (w_popcount)
   );

   // Only the response that answers the outstanding request is accepted
   assign w_resp_hit = i_rx_msg_valid && (i_rx_msg == resp_code(pend_q));

   // Next-state logic and bookkeeping counters
   always_comb begin
      state_d    = state_q;
      pend_d     = pend_q;
      count_d    = count_q;
      tmo_d      = tmo_q;
      attempts_d = attempts_q;
      reversed_d = reversed_q;

      if (!i_start) begin
         state_d    = ST_IDLE;
         pend_d     = c_msg_none;
         count_d    = '0;
         tmo_d      = '0;
         attempts_d = '0;
         reversed_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_WAIT_BUSY;
               pend_d  = c_msg_init_req;
            end
            ST_WAIT_BUSY: begin
               if (!i_sb_busy) state_d = ST_SEND;
            end
            ST_SEND: begin
               if (i_sb_busy_fall) begin
                  state_d = ST_WAIT_RESP;
                  tmo_d   = '0;
               end
            end
            ST_WAIT_RESP: begin
               // A response arriving on the timeout cycle still wins
               if (w_resp_hit) begin
                  case (pend_q)
                     c_msg_init_req: begin
                        state_d = ST_WAIT_BUSY;
                        pend_d  = c_msg_clear_error_req;
                     end
                     c_msg_clear_error_req: state_d = ST_PATTERN;
                     c_msg_result_req: begin
                        state_d = ST_EVAL;
                        count_d = w_popcount;
                     end
                     c_msg_done_req: state_d = ST_DONE;
                     default:        state_d = ST_ERROR;
                  endcase
               end else if (tmo_q >= c_tmo_last) begin
                  state_d = ST_ERROR;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end
            ST_PATTERN: begin
               if (i_pattern_done) begin
                  state_d = ST_WAIT_BUSY;
                  pend_d  = c_msg_result_req;
               end
            end
            ST_EVAL: begin
               if (count_q >= c_pass_thresh) begin
                  state_d = ST_WAIT_BUSY;
                  pend_d  = c_msg_done_req;
               end else if (attempts_q < c_max_rev) begin
                  // Reversal bookkeeping happens on APPLY entry
                  state_d    = ST_APPLY;
                  attempts_d = attempts_q + 2'd1;
                  reversed_d = ~reversed_q;
               end else begin
                  state_d = ST_ERROR;
               end
            end
            ST_APPLY: begin
               if (i_reversal_done) begin
                  state_d = ST_WAIT_BUSY;
                  pend_d  = c_msg_clear_error_req;
               end
            end
            ST_DONE:  state_d = ST_DONE;
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Output decode from the next state so every output is a flop
   always_comb begin
      tx_valid_d   = (state_d == ST_SEND);
      tx_msg_d     = tx_valid_d ? pend_d : c_msg_none;
      pattern_en_d = (state_d == ST_PATTERN) ? c_pat_lane_id : c_pat_off;
      apply_d      = (state_d == ST_APPLY) && (state_q != ST_APPLY);
      done_d       = (state_d == ST_DONE);
      train_err_d  = (state_d == ST_ERROR) && (state_q != ST_ERROR);
   end

   // State, counters and registered outputs
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         pend_q       <= c_msg_none;
         count_q      <= '0;
         tmo_q        <= '0;
         attempts_q   <= '0;
         reversed_q   <= 1'b0;
         tx_valid_q   <= 1'b0;
         tx_msg_q     <= c_msg_none;
         pattern_en_q <= c_pat_off;
         apply_q      <= 1'b0;
         done_q       <= 1'b0;
         train_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         pend_q       <= pend_d;
         count_q      <= count_d;
         tmo_q        <= tmo_d;
         attempts_q   <= attempts_d;
         reversed_q   <= reversed_d;
         tx_valid_q   <= tx_valid_d;
         tx_msg_q     <= tx_msg_d;
         pattern_en_q <= pattern_en_d;
         apply_q      <= apply_d;
         done_q       <= done_d;
         train_err_q  <= train_err_d;
      end
   end

   assign o_tx_msg         = tx_msg_q;
   assign o_tx_valid       = tx_valid_q;
   assign o_pattern_en     = pattern_en_q;
   assign o_apply_reversal = apply_q;
   assign o_reversed       = reversed_q;
   assign o_done           = done_q;
   assign o_train_error    = train_err_q;
   assign o_attempts       = attempts_q;

endmodule
`default_nettype wire

// File: tb/tb_mbinit_lane_reversal_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mbinit_lane_reversal_fsm
//  Description : Directed bench for the MBINIT lane-reversal step. A 16-lane
//                instance (short response timeout) and a 64-lane instance
//                share stimulus; obs_* selects which one is observed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mbinit_lane_reversal_fsm;

   logic        CLK = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic        i_sb_busy = 1'b0;
   logic        i_sb_busy_fall = 1'b0;
   logic [3:0]  i_rx_msg = 4'd0;
   logic        i_rx_msg_valid = 1'b0;
   logic [15:0] i_result16 = 16'd0;
   logic [63:0] i_result64 = 64'd0;
   logic        i_pattern_done = 1'b0;
   logic        i_reversal_done = 1'b0;

   logic [3:0] a_tx_msg, b_tx_msg;
   logic       a_tx_valid, b_tx_valid;
   logic [1:0] a_pattern_en, b_pattern_en;
   logic       a_apply, b_apply, a_reversed, b_reversed;
   logic       a_done, b_done, a_err, b_err;
   logic [1:0] a_attempts, b_attempts;

   logic       sel64 = 1'b0;
   logic [3:0] obs_tx_msg;
   logic       obs_tx_valid, obs_apply, obs_reversed, obs_done, obs_err;
   logic [1:0] obs_pattern_en, obs_attempts;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 CLK = ~CLK;

   mbinit_lane_reversal_fsm #(
      .NUM_LANES (16), .PASS_THRESH (9), .MAX_REV_ATTEMPTS (1), .RESP_TIMEOUT (100)
   ) dut (
      .CLK (CLK), .rst_n (rst_n), .i_start (i_start), .i_sb_busy (i_sb_busy),
      .i_sb_busy_fall (i_sb_busy_fall), .i_rx_msg (i_rx_msg), .i_rx_msg_valid (i_rx_msg_valid),
      .i_result (i_result16), .i_pattern_done (i_pattern_done), .i_reversal_done (i_reversal_done),
      .o_tx_msg (a_tx_msg), .o_tx_valid (a_tx_valid), .o_pattern_en (a_pattern_en),
      .o_apply_reversal (a_apply), .o_reversed (a_reversed), .o_done (a_done),
      .o_train_error (a_err), .o_attempts (a_attempts)
   );

   mbinit_lane_reversal_fsm #(
      .NUM_LANES (64), .PASS_THRESH (33), .MAX_REV_ATTEMPTS (1), .RESP_TIMEOUT (8000)
   ) dut64 (
      .CLK (CLK), .rst_n (rst_n), .i_start (i_start), .i_sb_busy (i_sb_busy),
      .i_sb_busy_fall (i_sb_busy_fall), .i_rx_msg (i_rx_msg), .i_rx_msg_valid (i_rx_msg_valid),
      .i_result (i_result64), .i_pattern_done (i_pattern_done), .i_reversal_done (i_reversal_done),
      .o_tx_msg (b_tx_msg), .o_tx_valid (b_tx_valid), .o_pattern_en (b_pattern_en),
      .o_apply_reversal (b_apply), .o_reversed (b_reversed), .o_done (b_done),
      .o_train_error (b_err), .o_attempts (b_attempts)
   );

   assign obs_tx_msg     = sel64 ? b_tx_msg     : a_tx_msg;
   assign obs_tx_valid   = sel64 ? b_tx_valid   : a_tx_valid;
   assign obs_pattern_en = sel64 ? b_pattern_en : a_pattern_en;
   assign obs_apply      = sel64 ? b_apply      : a_apply;
   assign obs_reversed   = sel64 ? b_reversed   : a_reversed;
   assign obs_done       = sel64 ? b_done       : a_done;
   assign obs_err        = sel64 ? b_err        : a_err;
   assign obs_attempts   = sel64 ? b_attempts   : a_attempts;

   // Sideband partner: wait for a request, end it with a busy-fall pulse,
   // optionally send an unrelated code first, then answer with resp.
   task automatic serve_req(input logic [3:0] junk, input logic [3:0] resp,
                            input logic [15:0] r16, input logic [63:0] r64,
                            output bit seen, output logic [3:0] code);
      seen = 1'b0;
      code = 4'd0;
      for (int k = 0; k < 40; k++) begin
         @(negedge CLK);
         if (obs_tx_valid) begin
            seen = 1'b1;
            code = obs_tx_msg;
            break;
         end
      end
      if (seen) begin
         i_sb_busy_fall = 1'b1;
         @(negedge CLK);
         i_sb_busy_fall = 1'b0;
         if (junk != 4'd0) begin
            i_rx_msg = junk;
            i_rx_msg_valid = 1'b1;
            @(negedge CLK);
         end
         i_rx_msg = resp;
         i_result16 = r16;
         i_result64 = r64;
         i_rx_msg_valid = 1'b1;
         @(negedge CLK);
         i_rx_msg_valid = 1'b0;
         i_rx_msg = 4'd0;
      end
   endtask

   // Wait for the lane-ID pattern request, then report the pattern complete
   task automatic run_pattern(output bit seen);
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge CLK);
         if (obs_pattern_en == 2'b11) begin
            seen = 1'b1;
            break;
         end
      end
      if (seen) begin
         i_pattern_done = 1'b1;
         @(negedge CLK);
         i_pattern_done = 1'b0;
      end
   endtask

   // Wait for the reversal-apply strobe
   task automatic wait_apply(output bit seen);
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge CLK);
         if (obs_apply) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic drop_start();
      i_start = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
   endtask

   task automatic test_reset();
      @(negedge CLK);
      tests_run++; if (obs_tx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_valid: got %0b expected 0", obs_tx_valid); end
      tests_run++; if (obs_tx_msg !== 4'd0) begin tests_failed++; $display("FAIL reset_tx_msg: got %0d expected 0", obs_tx_msg); end
      tests_run++; if ({obs_pattern_en, obs_apply, obs_reversed, obs_done, obs_err} !== 6'd0) begin tests_failed++; $display("FAIL reset_outputs: got %b expected 000000", {obs_pattern_en, obs_apply, obs_reversed, obs_done, obs_err}); end
      tests_run++; if (obs_attempts !== 2'd0) begin tests_failed++; $display("FAIL reset_attempts: got %0d expected 0", obs_attempts); end
      rst_n = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_pass_first();
      bit seen; logic [3:0] code;
      i_sb_busy = 1'b1;
      i_start = 1'b1;
      repeat (3) @(negedge CLK);
      tests_run++; if (obs_tx_valid !== 1'b0) begin tests_failed++; $display("FAIL busy_hold: got tx_valid %0b expected 0", obs_tx_valid); end
      i_sb_busy = 1'b0;
      @(negedge CLK);
      tests_run++; if (obs_tx_valid !== 1'b1 || obs_tx_msg !== 4'd1) begin tests_failed++; $display("FAIL busy_release: got valid %0b msg %0d expected valid 1 msg 1", obs_tx_valid, obs_tx_msg); end
      serve_req(4'd8, 4'd2, 16'h0000, 64'd0, seen, code);
      tests_run++; if (!seen || code !== 4'd1) begin tests_failed++; $display("FAIL pass_init: got seen %0b code %0d expected code 1", seen, code); end
      serve_req(4'd0, 4'd4, 16'h0000, 64'd0, seen, code);
      tests_run++; if (!seen || code !== 4'd3) begin tests_failed++; $display("FAIL pass_clear: got seen %0b code %0d expected code 3", seen, code); end
      run_pattern(seen);
      tests_run++; if (!seen) begin tests_failed++; $display("FAIL pass_pattern: got pattern_en %0d expected 3", obs_pattern_en); end
      serve_req(4'd0, 4'd6, 16'hFFFF, {64{1'b1}}, seen, code);
      tests_run++; if (!seen || code !== 4'd5) begin tests_failed++; $display("FAIL pass_result: got seen %0b code %0d expected code 5", seen, code); end
      serve_req(4'd0, 4'd8, 16'h0000, 64'd0, seen, code);
      tests_run++; if (!seen || code !== 4'd7) begin tests_failed++; $display("FAIL pass_done_req: got seen %0b code %0d expected code 7", seen, code); end
      @(negedge CLK);
      tests_run++; if (obs_done !== 1'b1 || obs_reversed !== 1'b0 || obs_attempts !== 2'd0) begin tests_failed++; $display("FAIL pass_final: got done %0b rev %0b att %0d expected 1 0 0", obs_done, obs_reversed, obs_attempts); end
      i_start = 1'b0;
      @(negedge CLK);
      tests_run++; if (obs_done !== 1'b0) begin tests_failed++; $display("FAIL pass_release: got done %0b expected 0", obs_done); end
      @(negedge CLK);
   endtask

   task automatic test_threshold16();
      bit seen; logic [3:0] code;
      i_start = 1'b1;
      serve_req(4'd0, 4'd2, 16'h0000, 64'd0, seen, code);
      serve_req(4'd0, 4'd4, 16'h0000, 64'd0, seen, code);
      run_pattern(seen);
      serve_req(4'd0, 4'd6, 16'h01FF, 64'd0, seen, code);
      serve_req(4'd0, 4'd8, 16'h0000, 64'd0, seen, code);
      tests_run++; if (!seen || code !== 4'd7 || obs_apply !== 1'b0) begin tests_failed++; $display("FAIL thresh_9of16: got seen %0b code %0d expected code 7", seen, code); end
      drop_start();
   endtask

   task automatic test_reversal();
      bit seen; logic [3:0] code;
      i_start = 1'b1;
      serve_req(4'd0, 4'd2, 16'h0000, 64'd0, seen, code);
      serve_req(4'd0, 4'd4, 16'h0000, 64'd0, seen, code);
      run_pattern(seen);
      serve_req(4'd0, 4'd6, 16'h00FF, 64'd0, seen, code);
      wait_apply(seen);
      tests_run++; if (!seen) begin tests_failed++; $display("FAIL rev_apply: got apply %0b expected 1", obs_apply); end
      tests_run++; if (obs_reversed !== 1'b1 || obs_attempts !== 2'd1) begin tests_failed++; $display("FAIL rev_flags: got rev %0b att %0d expected 1 1", obs_reversed, obs_attempts); end
      @(negedge CLK);
      tests_run++; if (obs_apply !== 1'b0) begin tests_failed++; $display("FAIL rev_pulse_width: got apply %0b expected 0", obs_apply); end
      i_reversal_done = 1'b1;
      @(negedge CLK);
      i_reversal_done = 1'b0;
      serve_req(4'd0, 4'd4, 16'h0000, 64'd0, seen, code);
      tests_run++; if (!seen || code !== 4'd3) begin tests_failed++; $display("FAIL rev_clear_resend: got seen %0b code %0d expected code 3", seen, code); end
      run_pattern(seen);
      serve_req(4'd0, 4'd6, 16'hFFFF, 64'd0, seen, code);
      serve_req(4'd0, 4'd8, 16'h0000, 64'd0, seen, code);
      tests_run++; if (!seen || code !== 4'd7) begin tests_failed++; $display("FAIL rev_done_req: got seen %0b code %0d expected code 7", seen, code); end
      @(negedge CLK);
      tests_run++; if (obs_done !== 1'b1 || obs_reversed !== 1'b1 || obs_attempts !== 2'd1) begin tests_failed++; $display("FAIL rev_final: got done %0b rev %0b att %0d expected 1 1 1", obs_done, obs_reversed, obs_attempts); end
      drop_start();
      tests_run++; if (obs_reversed !== 1'b0 || obs_attempts !== 2'd0) begin tests_failed++; $display("FAIL rev_clear_on_stop: got rev %0b att %0d expected 0 0", obs_reversed, obs_attempts); end
   endtask

   task automatic test_error();
      bit seen; logic [3:0] code;
      int err_cnt; int tx_cnt;
      i_start = 1'b1;
      serve_req(4'd0, 4'd2, 16'h0000, 64'd0, seen, code);
      serve_req(4'd0, 4'd4, 16'h0000, 64'd0, seen, code);
      run_pattern(seen);
      serve_req(4'd0, 4'd6, 16'h0001, 64'd0, seen, code);
      wait_apply(seen);
      i_reversal_done = 1'b1;
      @(negedge CLK);
      i_reversal_done = 1'b0;
      serve_req(4'd0, 4'd4, 16'h0000, 64'd0, seen, code);
      run_pattern(seen);
      serve_req(4'd0, 4'd6, 16'h0001, 64'd0, seen, code);
      err_cnt = 0;
      tx_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         if (obs_err) err_cnt++;
         if (obs_tx_valid) tx_cnt++;
         @(negedge CLK);
      end
      tests_run++; if (err_cnt != 1) begin tests_failed++; $display("FAIL err_pulse_count: got %0d expected 1", err_cnt); end
      tests_run++; if (tx_cnt != 0) begin tests_failed++; $display("FAIL err_no_done_req: got %0d tx cycles expected 0", tx_cnt); end
      tests_run++; if (obs_done !== 1'b0 || obs_attempts !== 2'd1) begin tests_failed++; $display("FAIL err_hold: got done %0b att %0d expected 0 1", obs_done, obs_attempts); end
      drop_start();
   endtask

   task automatic test_timeout();
      bit seen; logic [3:0] code;
      int k_hit;
      i_start = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge CLK);
         if (obs_tx_valid) begin seen = 1'b1; break; end
      end
      i_sb_busy_fall = 1'b1;
      @(negedge CLK);
      i_sb_busy_fall = 1'b0;
      k_hit = -1;
      for (int k = 0; k <= 150; k++) begin
         if (obs_err) begin k_hit = k; break; end
         @(negedge CLK);
      end
      tests_run++; if (!seen || k_hit != 100) begin tests_failed++; $display("FAIL timeout_cycle: got %0d expected 100", k_hit); end
      @(negedge CLK);
      tests_run++; if (obs_err !== 1'b0) begin tests_failed++; $display("FAIL timeout_pulse_width: got %0b expected 0", obs_err); end
      drop_start();
      // Response landing on the very cycle the timeout expires
      i_start = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge CLK);
         if (obs_tx_valid) break;
      end
      i_sb_busy_fall = 1'b1;
      @(negedge CLK);
      i_sb_busy_fall = 1'b0;
      repeat (99) @(negedge CLK);
      i_rx_msg = 4'd2;
      i_rx_msg_valid = 1'b1;
      @(negedge CLK);
      i_rx_msg_valid = 1'b0;
      i_rx_msg = 4'd0;
      tests_run++; if (obs_err !== 1'b0) begin tests_failed++; $display("FAIL resp_wins_err: got %0b expected 0", obs_err); end
      serve_req(4'd0, 4'd4, 16'h0000, 64'd0, seen, code);
      tests_run++; if (!seen || code !== 4'd3) begin tests_failed++; $display("FAIL resp_wins_next: got seen %0b code %0d expected code 3", seen, code); end
      drop_start();
   endtask

   task automatic test_abort();
      bit seen; logic [3:0] code;
      i_start = 1'b1;
      serve_req(4'd0, 4'd2, 16'h0000, 64'd0, seen, code);
      serve_req(4'd0, 4'd4, 16'h0000, 64'd0, seen, code);
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge CLK);
         if (obs_pattern_en == 2'b11) begin seen = 1'b1; break; end
      end
      i_start = 1'b0;
      @(negedge CLK);
      tests_run++; if (!seen || obs_pattern_en !== 2'b00) begin tests_failed++; $display("FAIL abort_pattern: got seen %0b pattern_en %0d expected 0", seen, obs_pattern_en); end
      i_start = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge CLK);
         if (obs_tx_valid) begin seen = 1'b1; break; end
      end
      tests_run++; if (!seen || obs_tx_msg !== 4'd1) begin tests_failed++; $display("FAIL abort_restart: got seen %0b msg %0d expected msg 1", seen, obs_tx_msg); end
      i_start = 1'b0;
      @(negedge CLK);
      tests_run++; if (obs_tx_valid !== 1'b0) begin tests_failed++; $display("FAIL abort_tx_drop: got %0b expected 0", obs_tx_valid); end
      @(negedge CLK);
   endtask

   task automatic test_lanes64();
      bit seen; logic [3:0] code;
      sel64 = 1'b1;
      i_start = 1'b1;
      serve_req(4'd0, 4'd2, 16'h0000, 64'd0, seen, code);
      serve_req(4'd0, 4'd4, 16'h0000, 64'd0, seen, code);
      run_pattern(seen);
      serve_req(4'd0, 4'd6, 16'hFFFF, 64'h0000_0001_FFFF_FFFF, seen, code);
      tests_run++; if (!seen || code !== 4'd5) begin tests_failed++; $display("FAIL l64_result_req: got seen %0b code %0d expected code 5", seen, code); end
      serve_req(4'd0, 4'd8, 16'h0000, 64'd0, seen, code);
      tests_run++; if (!seen || code !== 4'd7) begin tests_failed++; $display("FAIL l64_33_pass: got seen %0b code %0d expected code 7", seen, code); end
      @(negedge CLK);
      tests_run++; if (obs_done !== 1'b1) begin tests_failed++; $display("FAIL l64_done: got %0b expected 1", obs_done); end
      drop_start();
      i_start = 1'b1;
      serve_req(4'd0, 4'd2, 16'h0000, 64'd0, seen, code);
      serve_req(4'd0, 4'd4, 16'h0000, 64'd0, seen, code);
      run_pattern(seen);
      serve_req(4'd0, 4'd6, 16'hFFFF, 64'h0000_0000_FFFF_FFFF, seen, code);
      wait_apply(seen);
      tests_run++; if (!seen || obs_reversed !== 1'b1) begin tests_failed++; $display("FAIL l64_32_apply: got apply_seen %0b rev %0b expected 1 1", seen, obs_reversed); end
      drop_start();
      sel64 = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge CLK);
      test_reset();
      test_pass_first();
      test_threshold16();
      test_reversal();
      test_error();
      test_timeout();
      test_abort();
      test_lanes64();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit, got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
